sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbiter that merges the core's instruction-fetch and data-access SRAM-style ports onto one shared memory port with a variable-latency req/addr_ok/data_ok handshake. It sits directly downstream of the pipeline top and replaces the two fixed-latency SRAMs when the core moves to a unified memory. Exactly one transaction is outstanding at a time. Data requests win arbitration, and a starvation counter bounds how long instruction fetch can be locked out.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while an instruction request waits
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  load/store request
- data_wstrb  in  4  byte strobes; non-zero means write
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store done (1-cycle pulse)
- data_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_wr  out  1  write when 1
- mem_wstrb  out  4  byte strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: grant is combinational and goes to data if data_req=1, else to inst. Exception: if starve_cnt==STARVE_MAX and inst_req=1, grant goes to inst.
- The granted port sees addr_ok=1 in the same cycle. The non-granted port sees addr_ok=0. addr_ok is 0 in REQ and RESP.
- Accept (req & addr_ok): latch addr, wdata, wstrb and the source id (INST/DATA). Move to REQ.
- REQ: mem_req=1, driven only from the latched registers. mem_wr=(wstrb!=0). For inst, mem_wstrb=0 and mem_wr=0. When mem_addr_ok=1, move to RESP.
- RESP: mem_req=0. When mem_data_ok=1, register mem_rdata into the source's rdata. The next cycle, pulse that source's data_ok for exactly one cycle. Return to IDLE in that same cycle (pulse cycle = IDLE).
- mem_data_ok is ignored outside RESP. mem_addr_ok is ignored outside REQ.
- starve_cnt: increments (saturating at STARVE_MAX) on each data grant while inst_req=1. Clears on any inst grant. Holds otherwise.
- Stores also return data_data_ok. data_rdata for a store equals mem_rdata as sampled.
- Width rules: addresses and data pass through unmodified. No alignment checking.

## Timing
- Reset values: all *_ok, mem_req, mem_wr = 0. mem_wstrb, mem_addr, mem_wdata, both rdata = 0. FSM = IDLE. starve_cnt = 0.
- Minimum latency, with zero-wait memory: accept at T0, mem_req at T1 with mem_addr_ok at T1, mem_data_ok at T2, port data_ok at T3. A new grant is possible at T3.
- Throughput is 1 transaction per 3 cycles best case.
- Simultaneous inst_req and data_req in IDLE: data is granted unless starvation applies. The loser is not acknowledged and must hold its request.
- mem_addr_ok held low: the FSM stays in REQ indefinitely, with request fields stable.
- Reset mid-transaction: return immediately to reset values. No data_ok is issued. The memory shares the reset and drops its pending response.

## Structure
- Package sram_arb_pkg holds:
  - state enum (IDLE/REQ/RESP)
  - source id constants SRC_INST=0, SRC_DATA=1
  - default widths
- One sub-module, sram_arb_grant, contains the combinational grant plus the starve_cnt register. The top contains the FSM and datapath latches.

## Test plan
- Single load: data_req, addr 0x1c000100, mem responds 0xDEADBEEF with zero wait -> data_addr_ok at T0, mem_req at T1, data_data_ok=1 and data_rdata=0xDEADBEEF at T3, inst_data_ok stays 0.
- Store: data_wstrb=4'b0011, wdata 0x12345678 -> mem_wr=1, mem_wstrb=0011, mem_wdata=0x12345678 while in REQ, then one data_data_ok pulse.
- Contention: inst_req and data_req both held, STARVE_MAX=4 -> the grant sequence is D,D,D,D,I,D,D,D,D,I.
- Wait states: mem_addr_ok delayed 5 cycles and mem_data_ok 3 more -> mem_req/addr/wdata stay stable throughout, exactly one data_ok pulse, no other addr_ok during the wait.
- Spurious mem_data_ok in IDLE/REQ -> no data_ok and no state change.
- Reset asserted in RESP -> next cycle all outputs 0 and FSM IDLE; a later mem_data_ok is ignored.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, source ids and default widths for the SRAM arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: data-priority grant with a starvation counter that forces an instruction grant
// Ports: clk/reset; i_idle enables granting; i_inst_req/i_data_req requests;
//        o_gnt_inst/o_gnt_data one-hot combinational grants (only when the port requests).
module sram_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle,
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_gnt_inst,
  output logic o_gnt_data
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_cnt;
  logic w_starve;
  assign w_starve = (r_cnt == CW'(STARVE_MAX)) & i_inst_req;
  assign o_gnt_data = i_idle & i_data_req & ~w_starve;
  assign o_gnt_inst = i_idle & i_inst_req & (~i_data_req | w_starve);
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (o_gnt_inst) r_cnt <= '0;
    else if (o_gnt_data & i_inst_req & (r_cnt != CW'(STARVE_MAX))) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges instruction-fetch and data SRAM-style ports onto one variable-latency memory port
// Ports: inst_* fetch port, data_* load/store port (addr_ok accept, data_ok 1-cycle response),
//        mem_* shared memory port (req/addr_ok request phase, data_ok response phase).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t r_state, w_next;
  logic r_src, r_inst_ok, r_data_ok;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_inst_rdata, r_data_rdata;
  logic [3:0] r_wstrb;
  logic w_gnt_inst, w_gnt_data, w_done;
  sram_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk(clk),
    .reset(reset),
    .i_idle(r_state == IDLE),
    .i_inst_req(inst_req),
    .i_data_req(data_req),
    .o_gnt_inst(w_gnt_inst),
    .o_gnt_data(w_gnt_data)
  );
  assign w_done = (r_state == RESP) & mem_data_ok;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? ((w_gnt_inst | w_gnt_data) ? REQ : IDLE) :
             (r_state == REQ)  ? (mem_addr_ok ? RESP : REQ) :
             (r_state == RESP) ? (mem_data_ok ? IDLE : RESP) : IDLE;
    mem_req = r_state == REQ;
    mem_wr = mem_req & (r_wstrb != 4'b0);
  end
  // Fetches latch zero strobes and data so the request phase never looks like a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src        <= SRC_INST;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_ok <= w_done & (r_src == SRC_INST);
      r_data_ok <= w_done & (r_src == SRC_DATA);
      if (w_gnt_data) begin
        r_src   <= SRC_DATA;
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
        r_wstrb <= data_wstrb;
      end else if (w_gnt_inst) begin
        r_src   <= SRC_INST;
        r_addr  <= inst_addr;
        r_wdata <= '0;
        r_wstrb <= '0;
      end
      if (w_done & (r_src == SRC_INST)) r_inst_rdata <= mem_rdata;
      if (w_done & (r_src == SRC_DATA)) r_data_rdata <= mem_rdata;
    end
  end
  assign inst_addr_ok = w_gnt_inst;
  assign data_addr_ok = w_gnt_data;
  assign inst_data_ok = r_inst_ok;
  assign data_data_ok = r_data_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;
  assign mem_wstrb    = r_wstrb;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_addr_ok, data_data_ok;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    inst_req = 0; inst_addr = '0; data_req = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    #1;
    n_tests++; if ({mem_req, mem_wr, inst_data_ok, data_data_ok} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {mem_req, mem_wr, inst_data_ok, data_data_ok}); end
    n_tests++; if ({mem_wstrb, mem_addr, mem_wdata} !== 68'h0) begin n_fail++; $display("FAIL reset_mem_fields got %h exp 0", {mem_wstrb, mem_addr, mem_wdata}); end
    n_tests++; if ({inst_rdata, data_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {inst_rdata, data_rdata}); end
    reset = 0;
    cyc();
  endtask

  task automatic test_single_load;
    idle_inputs();
    data_req = 1; data_addr = 32'h1c000100;
    #1;
    n_tests++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL load_t0_addr_ok got %b exp 10", {data_addr_ok, inst_addr_ok}); end
    cyc();
    data_req = 0; mem_addr_ok = 1;
    #1;
    n_tests++; if ({mem_req, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL load_t1_req got %b exp 10", {mem_req, mem_wr}); end
    n_tests++; if (mem_addr !== 32'h1c000100) begin n_fail++; $display("FAIL load_t1_addr got %h exp 1c000100", mem_addr); end
    cyc();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_tests++; if ({mem_req, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL load_t2 got %b exp 00", {mem_req, data_data_ok}); end
    cyc();
    mem_data_ok = 0; mem_rdata = '0;
    #1;
    n_tests++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL load_t3_ok got %b exp 10", {data_data_ok, inst_data_ok}); end
    n_tests++; if (data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_t3_rdata got %h exp deadbeef", data_rdata); end
    cyc();
    #1;
    n_tests++; if (data_data_ok !== 1'b0) begin n_fail++; $display("FAIL load_t4_pulse got %b exp 0", data_data_ok); end
  endtask

  task automatic test_store;
    idle_inputs();
    data_req = 1; data_addr = 32'h1c000200; data_wstrb = 4'b0011; data_wdata = 32'h12345678;
    #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL store_addr_ok got %b exp 1", data_addr_ok); end
    cyc();
    data_req = 0; data_wdata = '0; data_wstrb = '0;
    for (int i = 0; i < 2; i++) begin
      mem_addr_ok = (i == 1);
      #1;
      n_tests++; if ({mem_req, mem_wr, mem_wstrb} !== 6'b110011) begin n_fail++; $display("FAIL store_req_fields got %b exp 110011", {mem_req, mem_wr, mem_wstrb}); end
      n_tests++; if (mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL store_wdata got %h exp 12345678", mem_wdata); end
      cyc();
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
    cyc();
    mem_data_ok = 0;
    #1;
    n_tests++; if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("FAIL store_done got %b/%h exp 1/cafef00d", data_data_ok, data_rdata); end
    cyc();
    #1;
    n_tests++; if ({data_data_ok, mem_req} !== 2'b00) begin n_fail++; $display("FAIL store_after got %b exp 00", {data_data_ok, mem_req}); end
  endtask

  task automatic test_contention;
    logic [9:0] seq = '0;
    int ng = 0, n_ip = 0, n_dp = 0;
    idle_inputs();
    reset = 1; cyc(); reset = 0;
    inst_req = 1; data_req = 1; inst_addr = 32'h1c000000; data_addr = 32'h1c008000;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h11112222;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      #1;
      n_tests++; if (inst_addr_ok & data_addr_ok) begin n_fail++; $display("FAIL contention_both_granted got 11 exp one-hot at cycle %0d", c); end
      if (inst_addr_ok) begin seq[ng] = 1'b1; ng++; end
      else if (data_addr_ok) begin seq[ng] = 1'b0; ng++; end
      n_ip += int'(inst_data_ok); n_dp += int'(data_data_ok);
      cyc();
    end
    inst_req = 0; data_req = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_ip += int'(inst_data_ok); n_dp += int'(data_data_ok);
      cyc();
    end
    n_tests++; if (ng !== 10) begin n_fail++; $display("FAIL contention_grants got %0d exp 10 within budget", ng); end
    n_tests++; if (seq !== 10'b1000010000) begin n_fail++; $display("FAIL contention_order got %b exp 1000010000 (bit i=1 means inst)", seq); end
    n_tests++; if (n_ip !== 2 || n_dp !== 8) begin n_fail++; $display("FAIL contention_pulses got inst=%0d data=%0d exp 2/8", n_ip, n_dp); end
  endtask

  task automatic test_wait_states;
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1c000040;
    #1;
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL wait_accept got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h1c00f000;
    for (int c = 1; c <= 10; c++) begin
      mem_addr_ok = (c == 6);
      mem_data_ok = (c == 10);
      mem_rdata = (c == 10) ? 32'h0BADF00D : 32'h0;
      #1;
      n_tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin n_fail++; $display("FAIL wait_quiet got %b exp 0000 at cycle %0d", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, c); end
      n_tests++; if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {c <= 6, 1'b0, 4'b0, (c <= 6) ? 32'h1c000040 : mem_addr, 32'h0}) begin n_fail++; $display("FAIL wait_fields got req=%b wr=%b addr=%h at cycle %0d", mem_req, mem_wr, mem_addr, c); end
      n_tests++; if (mem_addr !== 32'h1c000040) begin n_fail++; $display("FAIL wait_addr_stable got %h exp 1c000040 at cycle %0d", mem_addr, c); end
      cyc();
    end
    data_req = 0; mem_data_ok = 0; mem_rdata = '0;
    #1;
    n_tests++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h0BADF00D}) begin n_fail++; $display("FAIL wait_resp got %b %h exp 10 0badf00d", {inst_data_ok, data_data_ok}, inst_rdata); end
    cyc();
    #1;
    n_tests++; if ({inst_data_ok, mem_req} !== 2'b00) begin n_fail++; $display("FAIL wait_after got %b exp 00", {inst_data_ok, mem_req}); end
  endtask

  task automatic test_spurious;
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h99999999;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if ({mem_req, inst_data_ok, data_data_ok} !== 3'b0) begin n_fail++; $display("FAIL spurious_idle got %b exp 000 at cycle %0d", {mem_req, inst_data_ok, data_data_ok}, c); end
      cyc();
    end
    mem_data_ok = 0;
    data_req = 1; data_addr = 32'h1c000300;
    cyc();
    data_req = 0; mem_data_ok = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++; if ({mem_req, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL spurious_req got %b exp 10 at cycle %0d", {mem_req, data_data_ok}, c); end
      cyc();
    end
    mem_data_ok = 0; mem_addr_ok = 1;
    cyc();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h55AA55AA;
    cyc();
    mem_data_ok = 0;
    #1;
    n_tests++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h55AA55AA}) begin n_fail++; $display("FAIL spurious_resp got %b/%h exp 1/55aa55aa", data_data_ok, data_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    data_req = 1; data_addr = 32'h1c000400; data_wstrb = 4'b1111; data_wdata = 32'hA5A5A5A5;
    cyc();
    data_req = 0; mem_addr_ok = 1;
    cyc();
    mem_addr_ok = 0; reset = 1;
    cyc();
    reset = 0;
    #1;
    n_tests++; if ({mem_req, mem_wr, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok} !== 6'b0) begin n_fail++; $display("FAIL rstmid_flags got %b exp 000000", {mem_req, mem_wr, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}); end
    n_tests++; if ({mem_wstrb, mem_addr, mem_wdata, inst_rdata, data_rdata} !== 132'h0) begin n_fail++; $display("FAIL rstmid_fields got %h exp 0", {mem_wstrb, mem_addr, mem_wdata, inst_rdata, data_rdata}); end
    mem_data_ok = 1; mem_rdata = 32'h77777777;
    cyc();
    mem_data_ok = 0;
    data_req = 1; data_addr = 32'h1c000500; data_wstrb = '0; data_wdata = '0;
    #1;
    n_tests++; if ({data_data_ok, data_rdata, data_addr_ok} !== {1'b0, 32'h0, 1'b1}) begin n_fail++; $display("FAIL rstmid_late_resp got ok=%b rdata=%h addr_ok=%b exp 0/0/1", data_data_ok, data_rdata, data_addr_ok); end
    cyc();
    data_req = 0;
    #1;
    n_tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h1c000500}) begin n_fail++; $display("FAIL rstmid_new_req got %b/%h exp 1/1c000500", mem_req, mem_addr); end
    reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_load();
    test_store();
    test_contention();
    test_wait_states();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
